// File: rtl/ppa_seq_adder_pkg.sv
// Purpose: shared constants, state type and sizing helper for the sequenced PPA adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppa_pkg;

    localparam int WORD_W = 6;

    // Two-bit state encoding: IDLE=0, RUN=1, DONE=2.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the word index; never less than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ppa_seq_adder_if.sv
// Purpose: operand/result bundle between a requester and ppa_seq_adder.
// Latency: n/a (wires only).
// Backpressure: none; start is only sampled while the adder is idle, so the requester holds it.
// Ports: start/a_in/b_in/c_in from the requester; busy/done/sum/cout/ovf/zero back from the adder.
interface ppa_seq_adder_if
    import ppa_pkg::*;
#(
    parameter int WORDS = 4
);
    localparam int N = WORD_W * WORDS;

    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output start, a_in, b_in, c_in,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, a_in, b_in, c_in,
        output busy, done, sum, cout, ovf, zero
    );

endinterface

// File: rtl/ppa_seq_adder_adder.sv
// Purpose: 6-bit Kogge-Stone parallel-prefix adder with carry in/out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; c carry-in; w 6-bit sum; ov carry out of bit 5.
module PPA_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       c,
    output logic [5:0] w,
    output logic       ov
);
    logic [5:0] p0, g0, g1, p1, g2, p2, g3;

    assign p0 = a ^ b;
    // Carry-in folded into bit 0 generate so the prefix tree yields true carries.
    assign g0 = (a & b) | {5'b0, p0[0] & c};

    // Span 1, 2, 4; bits below the span pass through unchanged.
    assign g1 = g0 | (p0 & {g0[4:0], 1'b0});
    assign p1 = p0 & {p0[4:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[3:0], 2'b0});
    assign p2 = p1 & {p1[3:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[1:0], 4'b0});

    assign w  = p0 ^ {g3[4:0], c};
    assign ov = g3[5];

endmodule

// File: rtl/ppa_seq_adder.sv
// Purpose: WORDS x 6-bit adder built by running one PPA_adder over the words, LSW first.
// Latency: done pulses WORDS edges after the accepting edge; back-to-back period WORDS+2.
// Backpressure: start is ignored outside IDLE (no queuing); requester holds or re-asserts it.
// Ports: clk, rst (sync, active-high); bus = slave side of ppa_seq_adder_if.
module ppa_seq_adder
    import ppa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic           clk,
    input  logic           rst,
    ppa_seq_adder_if.slave bus
);
    localparam int N     = WORD_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [7:0]        word_base;
    logic [WORD_W-1:0] add_a, add_b, add_w;
    logic              add_ov;

    // Word select mux: the only path into the adder is registered operands + carry.
    assign word_base = 8'(idx_q) * 8'(WORD_W);
    assign add_a     = a_q[word_base +: WORD_W];
    assign add_b     = b_q[word_base +: WORD_W];

    PPA_adder u_adder (
        .a  (add_a),
        .b  (add_b),
        .c  (carry_q),
        .w  (add_w),
        .ov (add_ov)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[word_base +: WORD_W] = add_w;
                carry_d = add_ov;
                if (idx_q == IDX_LAST) begin
                    // Flags are taken from the completed sum so they are valid during DONE.
                    state_d = ST_DONE;
                    cout_d  = add_ov;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
                    zero_d  = ~|sum_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_ppa_seq_adder.sv
// Purpose: self-checking bench for ppa_seq_adder at WORDS=4 and WORDS=2.
// Latency: expects done WORDS edges after accept, busy for WORDS cycles.
// Backpressure: start held continuously must yield accepts WORDS+2 edges apart.
module tb_ppa_seq_adder;
    import ppa_pkg::*;

    typedef struct packed {
        int          acc;
        logic [23:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    ppa_seq_adder_if #(.WORDS(4)) if4 ();
    ppa_seq_adder_if #(.WORDS(2)) if2 ();

    ppa_seq_adder #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    ppa_seq_adder #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q4[$];
    exp_t q2[$];
    int   pushed4 = 0, pushed2 = 0, dones4 = 0, dones2 = 0;
    int   busy4 = 0, busy2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired waiting for DUT", name);
    endtask

    // Reference: whole-operand arithmetic on N=6*words bits.
    function automatic exp_t model(input int words, input logic [23:0] a, input logic [23:0] b,
                                   input logic c, input int acc);
        exp_t        e;
        int          n;
        logic [24:0] mask, am, bm, full;
        n     = 6 * words;
        mask  = (25'd1 << n) - 25'd1;
        am    = {1'b0, a} & mask;
        bm    = {1'b0, b} & mask;
        full  = am + bm + {24'd0, c};
        e.acc  = acc;
        e.sum  = full[23:0] & mask[23:0];
        e.cout = full[n];
        e.ovf  = (am[n-1] == bm[n-1]) && (e.sum[n-1] != am[n-1]);
        e.zero = (e.sum == 24'd0);
        return e;
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (if4.done === 1'b1) begin
            dones4++;
            chk("busy_low_in_done4", {63'd0, if4.busy}, 64'd0);
            chk("busy_cycles4", busy4, 4);
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done4: done with no outstanding operation at cycle %0d", cyc);
            end else begin
                e = q4.pop_front();
                chk("latency4", cyc - e.acc, 4);
                chk("sum4", if4.sum, e.sum);
                chk("cout4", if4.cout, e.cout);
                chk("ovf4", if4.ovf, e.ovf);
                chk("zero4", if4.zero, e.zero);
            end
            busy4 = 0;
        end else if (if4.busy === 1'b1) busy4++;
        else busy4 = 0;
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (if2.done === 1'b1) begin
            dones2++;
            chk("busy_cycles2", busy2, 2);
            if (q2.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done2: done with no outstanding operation at cycle %0d", cyc);
            end else begin
                e = q2.pop_front();
                chk("latency2", cyc - e.acc, 2);
                chk("sum2", if2.sum, e.sum);
                chk("cout2", if2.cout, e.cout);
                chk("ovf2", if2.ovf, e.ovf);
                chk("zero2", if2.zero, e.zero);
            end
            busy2 = 0;
        end else if (if2.busy === 1'b1) busy2++;
        else busy2 = 0;
    end

    task automatic wait_idle4();
        int t = 0;
        while ((if4.busy !== 1'b0 || if4.done !== 1'b0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("idle_wait4");
    endtask

    task automatic wait_idle2();
        int t = 0;
        while ((if2.busy !== 1'b0 || if2.done !== 1'b0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("idle_wait2");
    endtask

    task automatic op4(input logic [23:0] a, input logic [23:0] b, input logic c);
        wait_idle4();
        if4.a_in  = a;
        if4.b_in  = b;
        if4.c_in  = c;
        if4.start = 1'b1;
        q4.push_back(model(4, a, b, c, cyc + 1));
        pushed4++;
        @(negedge clk);
        if4.start = 1'b0;
        // Scramble inputs after acceptance; the captured operands must be used.
        if4.a_in  = 24'($urandom);
        if4.b_in  = 24'($urandom);
        if4.c_in  = 1'($urandom);
    endtask

    task automatic op2(input logic [11:0] a, input logic [11:0] b, input logic c);
        wait_idle2();
        if2.a_in  = a;
        if2.b_in  = b;
        if2.c_in  = c;
        if2.start = 1'b1;
        q2.push_back(model(2, {12'd0, a}, {12'd0, b}, c, cyc + 1));
        pushed2++;
        @(negedge clk);
        if2.start = 1'b0;
        if2.a_in  = 12'($urandom);
        if2.b_in  = 12'($urandom);
    endtask

    // start held high throughout; accepts are predicted every WORDS+2 edges.
    task automatic held4(input int nops);
        int next_acc;
        int got;
        wait_idle4();
        next_acc  = cyc + 1;
        got       = 0;
        if4.start = 1'b1;
        while (got < nops) begin
            if4.a_in = 24'($urandom);
            if4.b_in = 24'($urandom);
            if4.c_in = 1'($urandom);
            if (cyc + 1 == next_acc) begin
                q4.push_back(model(4, if4.a_in, if4.b_in, if4.c_in, next_acc));
                pushed4++;
                got++;
                next_acc += 6;
            end
            @(negedge clk);
        end
        if4.start = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        if4.start = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.c_in = 1'b0;
        if2.start = 1'b0; if2.a_in = '0; if2.b_in = '0; if2.c_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs4", {if4.busy, if4.done, if4.cout, if4.ovf, if4.zero, if4.sum}, 64'd0);
        chk("reset_outputs2", {if2.busy, if2.done, if2.cout, if2.ovf, if2.zero, if2.sum}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op4(24'h000000, 24'h000000, 1'b0);
        op4(24'hFFFFFF, 24'h000001, 1'b0);
        op4(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        op4(24'h7FFFFF, 24'h000001, 1'b0);
        op4(24'h123456, 24'h654321, 1'b1);
        op4(24'h800000, 24'h800000, 1'b0);
        for (int i = 0; i < 20; i++)
            op4(24'($urandom), 24'($urandom), 1'($urandom));

        held4(3);

        // Reset asserted on E2 of an operation: it must vanish without a done.
        wait_idle4();
        if4.a_in = 24'h00ABCD; if4.b_in = 24'h001111; if4.c_in = 1'b0; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs4", {if4.busy, if4.done, if4.cout, if4.ovf, if4.zero, if4.sum}, 64'd0);
        rst = 1'b0;
        op4(24'h000001, 24'h000001, 1'b0);

        op2(12'hFFF, 12'h001, 1'b0);
        op2(12'h7FF, 12'h001, 1'b0);
        op2(12'h000, 12'h000, 1'b0);
        for (int i = 0; i < 8; i++)
            op2(12'($urandom), 12'($urandom), 1'($urandom));

        t = 0;
        while ((q4.size() != 0 || q2.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("drain");
        repeat (4) @(negedge clk);
        chk("done_count4", dones4, pushed4);
        chk("done_count2", dones2, pushed2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppa_seq_adder.md
# ppa_seq_adder

Multi-word sequencing controller that performs a WORDS×6-bit addition by time-multiplexing a single 6-bit `PPA_adder` instance, one word per clock, least-significant word first. The carry is chained between words through a register. A start/busy/done handshake frames each operation. It sits between operand-producing logic and the existing 6-bit parallel-prefix adder, and extends that adder to wide operands without replicating it.

## Interface
Parameters:
- `WORDS`, default 4: number of 6-bit words per operand; total width N = 6·WORDS; legal range 2..16.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `a_in`  in  N  operand A; captured on the accepting edge.
- `b_in`  in  N  operand B; captured on the accepting edge.
- `c_in`  in  1  carry-in to word 0; captured on the accepting edge.
- `busy`  out  1  high in RUN.
- `done`  out  1  single-cycle pulse in DONE.
- `sum`  out  N  result; valid from DONE until the next accepted start.
- `cout`  out  1  carry out of the top word.
- `ovf`  out  1  two's-complement overflow of the N-bit sum.
- `zero`  out  1  sum == 0.

## Operation
- States are IDLE, RUN and DONE. The encoding is 2 bits.
- IDLE with `start`=1: latch `a_in`, `b_in` and `c_in` into operand registers. Clear word index `idx` to 0. Go to RUN.
- IDLE with `start`=0: hold all outputs.
- RUN, each edge:
  - Drive the adder with `a` = A word `idx`, `b` = B word `idx`, `c` = carry register. The carry register holds `c_in` when `idx`=0.
  - Write adder `w` into `sum[6·idx +: 6]`.
  - Load carry register from adder `ov`.
  - Increment `idx`.
  - On the edge where `idx`=WORDS−1, go to DONE instead of incrementing.
- DONE:
  - `done`=1 for exactly one cycle.
  - `cout` = final carry.
  - `ovf` = (A[N−1]==B[N−1]) && (sum[N−1]!=A[N−1]).
  - `zero` = ~|sum.
  - Next edge goes to IDLE.
- `sum`, `cout`, `ovf` and `zero` are held until the next accepted start. On that start edge, `sum` clears to 0.
- `start` in RUN or DONE is ignored. No queuing: the requester must hold or re-assert `start`.
- Operand registers are not affected by input changes after acceptance.
- `rst`=1 on any edge, including mid-RUN:
  - State goes to IDLE and `idx` to 0.
  - Carry register, `sum`, `cout`, `ovf`, `zero`, `busy` and `done` all go to 0.
  - An in-flight operation is discarded and no `done` is produced.
  - `rst` has priority over `start` on the same edge.
- Word arithmetic is exact 6-bit modular. Carry out of each word is only the adder's `ov`.

## Timing
- Accepting edge is E0. Words 0..WORDS−1 are written on edges E1..E_WORDS.
- `done` is high in the cycle after E_WORDS. Latency from the accepting edge to `done` is WORDS edges.
- `busy` is high from after E0 through E_WORDS−1's cycle, exactly WORDS cycles, and is low during DONE.
- Earliest next accept is edge E_WORDS+2. Back-to-back period is WORDS+2 cycles.
- The `PPA_adder` path is purely combinational between the operand/carry registers and the `sum`/carry registers. This is the single critical path.
- Reset values of all outputs are 0.

## Structure
- Shared package `ppa_pkg` holds:
  - `WORD_W` = 6.
  - State localparams `ST_IDLE`=0, `ST_RUN`=1, `ST_DONE`=2.
  - The index width function clog2(WORDS).
- One sub-module: the existing `PPA_adder` (ports a, b, c, w, ov), instantiated once, unmodified.
- Operand word select is an `idx`-driven mux. Shift registers are an acceptable alternative if the timing above is preserved.

## Test plan
All with WORDS=4 (N=24) unless noted.
- 0x000000 + 0x000000, c_in=0 → sum=0x000000, cout=0, zero=1, ovf=0. `done` comes 4 edges after accept, and `busy` is high for exactly 4 cycles.
- 0xFFFFFF + 0x000001, c_in=0 → sum=0x000000, cout=1, zero=1. Also 0xFFFFFF + 0xFFFFFF, c_in=1 → sum=0xFFFFFF, cout=1. These check carry propagation across every word boundary.
- 0x7FFFFF + 0x000001 → sum=0x800000, ovf=1, cout=0. 0x123456 + 0x654321, c_in=1 → sum=0x777778, ovf=0.
- Hold `start` high continuously and change `a_in` during RUN → only operands present at accept edges are used. Accepts land exactly 6 edges apart, and `done` pulses exactly once per operation.
- Assert `rst` on E2 of an operation → the next cycle shows IDLE with all outputs 0 and no `done`. A fresh start of 0x000001 + 0x000001 then gives 0x000002.
- Repeat with WORDS=2 (N=12): 0xFFF + 0x001 → sum=0x000, cout=1, with `done` 2 edges after accept.
